// File: rtl/rca8b_seq_ctrl_pkg.sv
// Shared types for the byte-serial multi-precision add/subtract sequencer.
package rca8b_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_ADD    = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Two's-complement subtract: invert B here, seed the carry chain with 1.
  function automatic logic [7:0] b_operand(input logic [7:0] b, input op_t op);
    return (op == OP_SUB) ? ~b : b;
  endfunction

endpackage

// File: rtl/rca8b_seq_ctrl_rca.sv
// Existing 8-bit ripple-carry adder, purely combinational.
module rca8b (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic w_c;

  always_comb begin
    o_sum = '0;
    w_c   = i_cin;
    for (int unsigned i = 0; i < 8; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/rca8b_seq_ctrl.sv
// Byte-serial NBYTES-wide add/subtract: load A then B LSB-first, add one byte
// per cycle through rca8b with a registered carry, stream the result out.
module rca8b_seq_ctrl
  import rca8b_seq_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_sub,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_cout,
  output logic       busy
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t          r_state, w_next;
  logic [7:0]      r_a [NBYTES];
  logic [7:0]      r_b [NBYTES];
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  op_t             r_sub;

  logic            w_in_fire, w_out_fire, w_at_last;
  logic [7:0]      w_sum;
  logic            w_cout;
  logic [IW-1:0]   w_idx_inc;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_at_last  = (r_idx == LAST_IDX);
  assign w_idx_inc  = w_at_last ? '0 : r_idx + IW'(1);

  rca8b u_rca8b (
    .i_a    (r_a[r_idx]),
    .i_b    (b_operand(r_b[r_idx], r_sub)),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_in_fire)              w_next = ST_LOAD_A;
      ST_LOAD_A: if (w_in_fire && w_at_last) w_next = ST_LOAD_B;
      ST_LOAD_B: if (w_in_fire && w_at_last) w_next = ST_ADD;
      ST_ADD:    if (w_at_last)              w_next = ST_OUT;
      ST_OUT:    if (w_out_fire && w_at_last) w_next = ST_IDLE;
      default:                               w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    busy      = (r_state != ST_IDLE);
    out_valid = (r_state == ST_OUT);
    out_data  = '0;
    out_last  = 1'b0;
    out_cout  = 1'b0;
    if (r_state == ST_OUT) begin
      out_data = r_a[r_idx];
      out_last = w_at_last;
      out_cout = w_at_last & r_carry;
    end
  end

  // The sum overwrites A in place, so OUT reads the result from r_a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sub   <= OP_ADD;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            r_a[0] <= in_data;
            r_sub  <= op_t'(in_sub);
            r_idx  <= IW'(1);
          end
        end
        ST_LOAD_A: begin
          if (w_in_fire) begin
            r_a[r_idx] <= in_data;
            r_idx      <= w_idx_inc;
          end
        end
        ST_LOAD_B: begin
          if (w_in_fire) begin
            r_b[r_idx] <= in_data;
            r_idx      <= w_idx_inc;
            if (w_at_last) r_carry <= (r_sub == OP_SUB);
          end
        end
        ST_ADD: begin
          r_a[r_idx] <= w_sum;
          r_carry    <= w_cout;
          r_idx      <= w_idx_inc;
        end
        ST_OUT: begin
          if (w_out_fire) r_idx <= w_idx_inc;
        end
        default: r_idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rca8b_seq_ctrl.sv
// Directed table-driven bench for rca8b_seq_ctrl with NBYTES=4.
module tb_rca8b_seq_ctrl;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_cout;
  logic       busy;

  rca8b_seq_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
  } vec_t;

  vec_t vecs [8];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // in_sub is inverted on every byte after the first: it must only be sampled once.
  task automatic send_op(input logic sub, input logic [31:0] a, input logic [31:0] b, input bit gaps);
    logic [63:0] stream;
    stream = {b, a};
    for (int i = 0; i < 2 * NB; i++) begin
      send_byte(stream[8*i +: 8], (i == 0) ? sub : ~sub);
      if (gaps && i < 2 * NB - 1) begin
        repeat ($urandom_range(0, 2)) begin
          check("in_ready_load_gap", 32'(in_ready), 32'd1);
          tick();
        end
      end
    end
  endtask

  task automatic recv_byte(output logic [7:0] d, output logic last, output logic c);
    int waited = 0;
    out_ready = 1'b1;
    while (!out_valid && waited < 50) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      tick();
      waited++;
    end
    check("out_valid", 32'(out_valid), 32'd1);
    check("in_ready_out", 32'(in_ready), 32'd0);
    d    = out_data;
    last = out_last;
    c    = out_cout;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic recv_result(input string tag, input logic [31:0] res, input logic ec);
    logic [7:0] d;
    logic       l, c;
    for (int i = 0; i < NB; i++) begin
      recv_byte(d, l, c);
      check($sformatf("%s_byte%0d", tag, i), 32'(d), 32'(res[8*i +: 8]));
      check($sformatf("%s_last%0d", tag, i), 32'(l), (i == NB - 1) ? 32'd1 : 32'd0);
      check($sformatf("%s_cout%0d", tag, i), 32'(c), (i == NB - 1) ? 32'(ec) : 32'd0);
    end
    check($sformatf("%s_idle", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       l, c;
    int         k;

    //             sub   a             b             result        cout
    vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0};

    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_cout",  32'(out_cout),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    #5 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      send_op(vecs[i].sub, vecs[i].a, vecs[i].b, 1'b0);
      recv_result($sformatf("vec%0d", i), vecs[i].res, vecs[i].cout);
    end

    // Latency: accept cycle of the last B byte counts as cycle 1.
    for (int i = 0; i < NB; i++) send_byte(i == 0 ? 8'hFF : 8'h00, 1'b0);
    for (int i = 0; i < NB; i++) send_byte(i == 0 ? 8'h01 : 8'h00, 1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      check("add_busy", 32'(busy), 32'd1);
      tick();
      k++;
    end
    check("latency", 32'(k + 1), 32'(NB + 1));
    recv_result("lat", 32'h0000_0100, 1'b0);

    // Backpressure on byte index 1.
    send_op(1'b0, 32'h1122_3344, 32'h1111_1111, 1'b0);
    recv_byte(d, l, c);
    check("bp_byte0", 32'(d), 32'h55);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data",  32'(out_data),  32'h44);
      check("bp_hold_last",  32'(out_last),  32'd0);
      tick();
    end
    recv_byte(d, l, c);
    check("bp_byte1", 32'(d), 32'h44);
    recv_byte(d, l, c);
    check("bp_byte2", 32'(d), 32'h33);
    recv_byte(d, l, c);
    check("bp_byte3", 32'(d), 32'h22);
    check("bp_last3", 32'(l), 32'd1);
    check("bp_cout3", 32'(c), 32'd0);
    check("bp_idle",  32'(busy), 32'd0);

    // Random in_valid gaps while loading.
    send_op(1'b0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b1);
    recv_result("gaps", 32'hDFAE_BFF0, 1'b0);

    // Asynchronous reset in the middle of LOAD_B, away from any clock edge.
    for (int i = 0; i < NB; i++) send_byte(8'h09, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h77, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    check("arst_out_last",  32'(out_last),  32'd0);
    check("arst_out_cout",  32'(out_cout),  32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_op(1'b0, 32'h0000_0002, 32'h0000_0003, 1'b0);
    recv_result("post_rst", 32'h0000_0005, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
